// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, per-register busy scoreboard
// and a sequential clear sweep that runs after reset or on request.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req_i,
    output logic                 ready_o,
    input  logic [NWR-1:0]       wr_en_i,
    input  logic [NWR*AW-1:0]    wr_addr_i,
    input  logic [NWR*XLEN-1:0]  wr_data_i,
    input  logic                 sb_set_i,
    input  logic [AW-1:0]        sb_addr_i,
    input  logic [NRD-1:0]       rd_en_i,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD*XLEN-1:0]  rd_data_o,
    output logic [NRD-1:0]       rd_busy_o
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q;

    // Out-of-range addresses and the hardwired zero register are never stored or read.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == AW'(NREGS - 1)) begin
                    state_d   = RUN;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                if (clr_req_i) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
        endcase
    end

    assign ready_o = (state_q == RUN);

    // Later write ports and sb_set are applied last so they take priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs_q[clr_ptr_q] <= '0;
                busy_q[clr_ptr_q] <= 1'b0;
            end else if (!clr_req_i) begin
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (wr_en_i[i] && addr_ok(wr_addr_i[i*AW +: AW])) begin
                        regs_q[wr_addr_i[i*AW +: AW]] <= wr_data_i[i*XLEN +: XLEN];
                        busy_q[wr_addr_i[i*AW +: AW]] <= 1'b0;
                    end
                end
                if (sb_set_i && addr_ok(sb_addr_i)) begin
                    busy_q[sb_addr_i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        ra        = '0;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            ra = rd_addr_i[j*AW +: AW];
            if (rd_en_i[j] && ready_o && addr_ok(ra)) begin
                rd_data_o[j*XLEN +: XLEN] = regs_q[ra];
                rd_busy_o[j]              = busy_q[ra];
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (wr_en_i[i] && (wr_addr_i[i*AW +: AW] == ra)) begin
                        rd_data_o[j*XLEN +: XLEN] = wr_data_i[i*XLEN +: XLEN];
                        rd_busy_o[j]              = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: sweep timing, bypass, write priority, zero register,
// out-of-range addresses, scoreboard and clear/reset behaviour.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        ready, ready24;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data24;
    logic [1:0]  rd_busy, rd_busy24;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .clr_req_i(clr_req), .ready_o(ready),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_busy_o(rd_busy)
    );

    regfile_mp #(.NREGS(24)) u_dut24 (
        .clk(clk), .rst(rst), .clr_req_i(clr_req), .ready_o(ready24),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data24), .rd_busy_o(rd_busy24)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]           = en;
        wr_addr[p*5 +: 5]  = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic set_rd(input int p, input logic en, input logic [4:0] a);
        rd_en[p]          = en;
        rd_addr[p*5 +: 5] = a;
    endtask

    task automatic wr_off();
        wr_en  = '0;
        sb_set = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
        sb_set = 1'b0; sb_addr = '0; rd_en = '0; rd_addr = '0;
        step();
        rst = 1'b0;
        set_rd(0, 1'b1, 5'd5);

        // Reset sweep: ready low for 32 cycles, reads forced to zero meanwhile
        for (int k = 0; k < 32; k++) begin
            #1;
            chk("sweep_ready", 32'(ready), 32'd0);
            if (k == 3) chk("sweep_rd_zero", rd_data[31:0], 32'd0);
            if (k == 23) chk("ready24_low", 32'(ready24), 32'd0);
            if (k == 24) chk("ready24_high", 32'(ready24), 32'd1);
            step();
        end
        chk("ready_high", 32'(ready), 32'd1);
        for (int a = 0; a < 32; a++) begin
            set_rd(0, 1'b1, 5'(a));
            #1;
            if (rd_data[31:0] !== 32'd0 || rd_busy[0] !== 1'b0)
                chk("post_reset_rd", rd_data[31:0], 32'd0);
        end
        chk("post_reset_rd_x31", rd_data[31:0], 32'd0);

        // Same-cycle bypass then array read
        set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
        set_rd(0, 1'b1, 5'd5);
        #1;
        chk("bypass_data", rd_data[31:0], 32'hDEADBEEF);
        chk("bypass_busy", 32'(rd_busy[0]), 32'd0);
        step(); wr_off(); #1;
        chk("array_data", rd_data[31:0], 32'hDEADBEEF);

        // Two ports, same address: port 1 wins
        set_wr(0, 1'b1, 5'd7, 32'h11);
        set_wr(1, 1'b1, 5'd7, 32'h22);
        set_rd(0, 1'b1, 5'd7);
        #1;
        chk("prio_bypass", rd_data[31:0], 32'h22);
        step(); wr_off(); #1;
        chk("prio_array", rd_data[31:0], 32'h22);

        // Hardwired zero register
        set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        sb_set = 1'b1; sb_addr = 5'd0;
        set_rd(0, 1'b1, 5'd0);
        #1;
        chk("x0_bypass", rd_data[31:0], 32'd0);
        step(); wr_off(); #1;
        chk("x0_data", rd_data[31:0], 32'd0);
        chk("x0_busy", 32'(rd_busy[0]), 32'd0);

        // 24-entry instance: top register usable, address 30 ignored
        set_wr(0, 1'b1, 5'd23, 32'hA5);
        step(); wr_off();
        set_wr(0, 1'b1, 5'd30, 32'h12345678);
        set_rd(0, 1'b1, 5'd30);
        set_rd(1, 1'b1, 5'd23);
        #1;
        chk("n24_oob_bypass", rd_data24[31:0], 32'd0);
        chk("n24_x23", rd_data24[63:32], 32'hA5);
        step(); wr_off(); #1;
        chk("n24_oob_read", rd_data24[31:0], 32'd0);
        chk("n24_x23_kept", rd_data24[63:32], 32'hA5);

        // Scoreboard
        sb_set = 1'b1; sb_addr = 5'd3;
        step(); wr_off();
        set_rd(0, 1'b1, 5'd3);
        set_rd(1, 1'b1, 5'd5);
        #1;
        chk("sb_busy", 32'(rd_busy[0]), 32'd1);
        chk("sb_port1_busy", 32'(rd_busy[1]), 32'd0);
        chk("sb_port1_data", rd_data[63:32], 32'hDEADBEEF);
        set_wr(0, 1'b1, 5'd3, 32'h55);
        #1;
        chk("sb_wr_busy", 32'(rd_busy[0]), 32'd0);
        chk("sb_wr_data", rd_data[31:0], 32'h55);
        step(); wr_off(); #1;
        chk("sb_after_busy", 32'(rd_busy[0]), 32'd0);
        chk("sb_after_data", rd_data[31:0], 32'h55);
        set_wr(1, 1'b1, 5'd3, 32'h66);
        sb_set = 1'b1; sb_addr = 5'd3;
        step(); wr_off(); #1;
        chk("sb_set_wins", 32'(rd_busy[0]), 32'd1);
        chk("sb_set_data", rd_data[31:0], 32'h66);
        set_rd(1, 1'b0, 5'd5);
        #1;
        chk("rd_en_off", rd_data[63:32], 32'd0);

        // Fill, then requested clear sweep
        for (int a = 1; a < 32; a++) begin
            set_wr(0, 1'b1, 5'(a), 32'h01010101 * 32'(a));
            step();
        end
        wr_off();
        set_rd(0, 1'b1, 5'd31);
        #1;
        chk("fill_x31", rd_data[31:0], 32'h1F1F1F1F);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #1;
            if (k == 0 || k == 31) chk("clr_ready", 32'(ready), 32'd0);
            if (k == 30) set_wr(0, 1'b1, 5'd4, 32'h77);
            step();
            wr_off();
        end
        chk("clr_ready_high", 32'(ready), 32'd1);
        for (int a = 0; a < 32; a++) begin
            set_rd(0, 1'b1, 5'(a));
            #1;
            if (rd_data[31:0] !== 32'd0 || rd_busy[0] !== 1'b0)
                chk("clr_rd", rd_data[31:0], 32'd0);
        end
        set_rd(0, 1'b1, 5'd4);
        #1;
        chk("clr_x4_dropped", rd_data[31:0], 32'd0);
        set_rd(0, 1'b1, 5'd3);
        #1;
        chk("clr_x3_busy", 32'(rd_busy[0]), 32'd0);

        // Reset in the middle of a sweep restarts it
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #1;
            if (k == 31) chk("rst_mid_ready", 32'(ready), 32'd0);
            step();
        end
        chk("rst_mid_ready_high", 32'(ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
